dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester controller that shares the single-port byte-addressed data memory between the CPU MEM stage (port 0) and a secondary master such as a DMA or debug loader (port 1). Each requester uses a req/ack handshake. A round-robin arbiter grants one requester at a time, and an FSM sequences each access over a fixed latency. The block sits directly in front of the data memory and owns its address, write-data and strobe inputs.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (one word = 4 bytes, little-endian in memory)
- MEM_BYTES, 32, memory size in bytes, used by the range check
- LAT, 2, number of ACCESS cycles per transfer (≥1)

- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset, synchronous, active-low
- req0_i / req1_i  input  1  access request, held until ack
- we0_i / we1_i  input  1  1 = write, 0 = read
- addr0_i / addr1_i  input  ADDR_W  byte address
- wdata0_i / wdata1_i  input  DATA_W  write data
- ack0_o / ack1_o  output  1  one-cycle completion pulse
- rdata0_o / rdata1_o  output  DATA_W  read data, registered
- err0_o / err1_o  output  1  access rejected, valid with ack
- mem_addr_o  output  ADDR_W  memory address
- mem_wdata_o  output  DATA_W  memory write data
- mem_write_o  output  1  memory write strobe
- mem_read_o  output  1  memory read enable
- mem_rdata_i  input  DATA_W  memory combinational read data
- busy_o  output  1  FSM not in IDLE

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- IDLE:
  - With no request, the FSM stays in IDLE.
  - With any req*_i high, the arbiter picks a winner and the FSM latches that port's we, addr and wdata. The FSM then moves to ACCESS and loads cnt = LAT-1.
- Round-robin arbitration:
  - When both ports request, the grant goes to the port that was not granted last.
  - last_grant updates on every grant.
  - last_grant resets to 1, so port 0 wins the first contested arbitration.
- ACCESS:
  - mem_addr_o and mem_wdata_o are driven from the latched registers.
  - For a read, mem_read_o is high on every ACCESS cycle.
  - For a write, mem_write_o is high only when cnt == 0, giving exactly one write edge per transfer.
  - cnt decrements each cycle. When cnt == 0, a read captures mem_rdata_i into the granted port's rdata register, and the FSM moves to RESP.
- RESP:
  - The granted port's ack is high for one cycle. The FSM then returns to IDLE.
  - Requests are not sampled in RESP.
- Requester rules:
  - A requester holds req, we, addr and wdata stable until its ack.
  - A requester must drop req in the cycle after ack unless it is issuing a new request. A req still high when the FSM is in IDLE is a new request.
- rdata*_o holds its value until the next successful read on that port. Writes do not change it.
- A non-granted requester simply waits. No request is ever lost.
- Memory outputs are 0 and strobes are low outside ACCESS.

## Timing
- Reset, when rst_i is low at a clock edge:
  - state returns to IDLE, cnt = 0 and last_grant = 1.
  - All outputs (ack*, err*, rdata*, mem_*, busy_o) go to 0.
  - An in-flight transfer is abandoned: it gets no ack, and no write strobe is issued after the reset edge.
- Latency: a request is sampled in IDLE at cycle 0. ACCESS occupies cycles 1..LAT, and ack is high in cycle LAT+1. With LAT = 2, ack arrives in cycle 3.
- Throughput: one transfer per LAT+2 cycles, which includes the IDLE re-arbitration cycle.
- busy_o is high in ACCESS and RESP.
- If both requests rise in the same cycle, the single grant follows the round-robin rule. The loser is granted at its next IDLE, LAT+2 cycles later.
- Request signals are ignored while the FSM is in ACCESS or RESP.

## Configuration
- Macro: DMEM_ARB_ALIGN_CHECK_EN.
- With DMEM_ARB_ALIGN_CHECK_EN defined:
  - At grant time, the block checks for a misaligned address (addr[1:0] != 0) or an out-of-range address (addr > MEM_BYTES-4).
  - A failing address skips ACCESS: the FSM goes IDLE→RESP, and ack and err are both high for one cycle.
  - No memory strobe is issued, and rdata is unchanged.
  - Total latency for a rejected access is 1 cycle.
- Without the macro, err*_o are tied to 0 and every access goes through ACCESS.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - REQ_N = 2;
  - the port index constants PORT_CPU = 0 and PORT_AUX = 1.
- Sub-module rr_arbiter2 contains the two-request round-robin grant logic and the last_grant register, with an update enable. The FSM, latches and counter stay in dmem_arbiter.

## Test plan
- Single read: preload memory byte 8 = 0x11, byte 9 = 0x22, byte 10 = 0x33, byte 11 = 0x44, i.e. word 0x44332211 at address 8. Port 0 reads addr 8 with LAT = 2 → ack0_o high in cycle 3, rdata0_o = 0x44332211, mem_write_o never high.
- Single write then read: port 1 writes 0xDEADBEEF to addr 12 → mem_write_o high for exactly 1 cycle. A following read of addr 12 on port 0 → rdata0_o = 0xDEADBEEF.
- Contention: both ports request in the same cycle right after reset → port 0 acks first (cycle 3) and port 1 acks in cycle 7. A repeat of the contention → port 1 is served first.
- Reset mid-write: drop rst_i during the first ACCESS cycle of a write to addr 4 → no ack, memory at addr 4 unchanged, all outputs 0 on the cycle after reset.
- Align check, with DMEM_ARB_ALIGN_CHECK_EN defined: port 0 writes to addr 2 → ack0_o and err0_o high in cycle 1, no mem strobe. Port 0 reads addr 32 → err0_o = 1. Without the macro, err0_o stays 0 throughout.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and port constants for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam int REQ_N    = 2;
    localparam int PORT_CPU = 0;
    localparam int PORT_AUX = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-request round-robin grant with last_grant register; port 0 wins first tie
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REQ_N-1:0] req,
    input  logic             en,
    output logic             gnt
);

    logic last;

    always_ff @(posedge clk)
        if (!rst_n) last <= 1'b1;
        else if (en) last <= gnt;

    always_comb gnt = (req[PORT_CPU] && req[PORT_AUX]) ? ~last : req[PORT_AUX];

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port req/ack front end for single-port data memory; DMEM_ARB_ALIGN_CHECK_EN enables address rejection
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 32,
    parameter int LAT       = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack0_o,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              err0_o,
    output logic              err1_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    if (LAT < 1 || MEM_BYTES < 4) begin : g_cfg_check
        $error("dmem_arbiter: LAT must be >= 1 and MEM_BYTES >= 4");
    end

    state_t             state, next;
    logic [CW-1:0]      cnt;
    logic               sel, lwe, lerr, gnt, bad, take;
    logic [ADDR_W-1:0]  laddr, addr;
    logic [DATA_W-1:0]  lwdata;
    logic [DATA_W-1:0]  rdata [REQ_N];
    logic [REQ_N-1:0]   req;

    assign req  = {req1_i, req0_i};
    assign take = (state == IDLE) && |req;
    assign addr = gnt ? addr1_i : addr0_i;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign bad = (addr[1:0] != 2'b00) || (addr > ADDR_W'(MEM_BYTES - 4));
`else
    assign bad = 1'b0;
`endif

    rr_arbiter2 u_arb (
        .clk  (clk_i),
        .rst_n(rst_i),
        .req  (req),
        .en   (take),
        .gnt  (gnt)
    );

    always_ff @(posedge clk_i)
        if (!rst_i) state <= IDLE;
        else state <= next;

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (|req) next = bad ? RESP : ACCESS;
            ACCESS:  if (cnt == '0) next = RESP;
            RESP:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i)
        if (!rst_i) begin
            cnt      <= '0;
            sel      <= 1'b0;
            lwe      <= 1'b0;
            lerr     <= 1'b0;
            laddr    <= '0;
            lwdata   <= '0;
            rdata[0] <= '0;
            rdata[1] <= '0;
        end else if (take) begin
            cnt    <= CW'(LAT - 1);
            sel    <= gnt;
            lwe    <= gnt ? we1_i : we0_i;
            laddr  <= addr;
            lwdata <= gnt ? wdata1_i : wdata0_i;
            lerr   <= bad;
        end else if (state == ACCESS) begin
            cnt <= cnt - CW'(cnt != '0);
            if (cnt == '0 && !lwe) rdata[sel] <= mem_rdata_i;
        end

    // Memory bus is quiet outside ACCESS; writes strobe only on the final cycle
    always_comb begin
        ack0_o      = (state == RESP) && (sel == 1'(PORT_CPU));
        ack1_o      = (state == RESP) && (sel == 1'(PORT_AUX));
        err0_o      = ack0_o && lerr;
        err1_o      = ack1_o && lerr;
        busy_o      = state != IDLE;
        mem_addr_o  = (state == ACCESS) ? laddr : '0;
        mem_wdata_o = (state == ACCESS) ? lwdata : '0;
        mem_read_o  = (state == ACCESS) && !lwe;
        mem_write_o = (state == ACCESS) && lwe && (cnt == '0);
    end

    assign rdata0_o = rdata[PORT_CPU];
    assign rdata1_o = rdata[PORT_AUX];

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a 32-byte little-endian memory model
module tb_dmem_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        load = 1'b1;
    logic        req0_i = 1'b0, req1_i = 1'b0, we0_i = 1'b0, we1_i = 1'b0;
    logic [31:0] addr0_i = '0, addr1_i = '0, wdata0_i = '0, wdata1_i = '0;
    logic        ack0_o, ack1_o, err0_o, err1_o, mem_write_o, mem_read_o, busy_o;
    logic [31:0] rdata0_o, rdata1_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [7:0]  mem [32];
    logic [31:0] last_rd [2];
    exp_t        q0[$], q1[$];
    int          vec = 0, miss = 0, wr_cnt = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk_i(clk), .rst_i(rst_i),
        .req0_i(req0_i), .req1_i(req1_i), .we0_i(we0_i), .we1_i(we1_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .ack0_o(ack0_o), .ack1_o(ack1_o), .rdata0_o(rdata0_o), .rdata1_o(rdata1_o),
        .err0_o(err0_o), .err1_o(err1_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_write_o(mem_write_o), .mem_read_o(mem_read_o),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    always @(posedge clk)
        if (load) begin
            for (int k = 0; k < 32; k++) mem[k] <= 8'h00;
            mem[4] <= 8'hA5; mem[5] <= 8'h5A; mem[6] <= 8'hC3; mem[7] <= 8'h3C;
            mem[8] <= 8'h11; mem[9] <= 8'h22; mem[10] <= 8'h33; mem[11] <= 8'h44;
        end else if (mem_write_o) begin
            for (int k = 0; k < 4; k++)
                if (mem_addr_o < 32'(32 - k)) mem[int'(mem_addr_o[4:0]) + k] <= mem_wdata_o[8*k +: 8];
        end

    always_comb begin
        mem_rdata_i = '0;
        for (int k = 0; k < 4; k++)
            if (mem_addr_o < 32'(32 - k)) mem_rdata_i[8*k +: 8] = mem[int'(mem_addr_o[4:0]) + k];
    end

    always @(negedge clk)
        if (rst_i) begin
            exp_t e;
            if (mem_write_o) wr_cnt++;
            if (ack0_o) begin
                vec++;
                if (q0.size() == 0) begin
                    miss++; $display("FAIL ack0_unexpected: got ack0 with no pending request");
                end else begin
                    e = q0.pop_front();
                    if ({rdata0_o, err0_o} !== {e.data, e.err}) begin
                        miss++; $display("FAIL port0_resp: rdata=%h err=%b, want rdata=%h err=%b", rdata0_o, err0_o, e.data, e.err);
                    end
                end
            end
            if (ack1_o) begin
                vec++;
                if (q1.size() == 0) begin
                    miss++; $display("FAIL ack1_unexpected: got ack1 with no pending request");
                end else begin
                    e = q1.pop_front();
                    if ({rdata1_o, err1_o} !== {e.data, e.err}) begin
                        miss++; $display("FAIL port1_resp: rdata=%h err=%b, want rdata=%h err=%b", rdata1_o, err1_o, e.data, e.err);
                    end
                end
            end
            if ((err0_o && !ack0_o) || (err1_o && !ack1_o)) begin
                miss++; $display("FAIL err_without_ack: err0=%b ack0=%b err1=%b ack1=%b", err0_o, ack0_o, err1_o, ack1_o);
            end
        end

    task automatic drive(input int p, input logic we, input logic [31:0] a, input logic [31:0] d, input logic on);
        if (p == 0) begin req0_i = on; we0_i = we; addr0_i = a; wdata0_i = d; end
        else begin req1_i = on; we1_i = we; addr1_i = a; wdata1_i = d; end
    endtask

    task automatic expect_resp(input int p, input logic we, input logic [31:0] rd, input logic err);
        exp_t e;
        if (!we && !err) last_rd[p] = rd;
        e.data = last_rd[p];
        e.err  = err;
        if (p == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic access(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rd, input logic exp_err, input int exp_wr);
        int n = 0;
        int w0 = wr_cnt;
        @(negedge clk);
        expect_resp(p, we, exp_rd, exp_err);
        drive(p, we, a, wd, 1'b1);
        do begin
            @(negedge clk);
            n++;
        end while (!(p == 0 ? ack0_o : ack1_o) && n < 20);
        drive(p, we, a, wd, 1'b0);
        vec++;
        if (n != exp_lat) begin
            miss++; $display("FAIL latency p%0d addr=%h: ack after %0d cycles, want %0d", p, a, n, exp_lat);
        end
        @(negedge clk);
        vec++;
        if ({ack0_o, ack1_o, busy_o} !== 3'b000) begin
            miss++; $display("FAIL ack_pulse p%0d: ack0=%b ack1=%b busy=%b one cycle after ack, want 0", p, ack0_o, ack1_o, busy_o);
        end
        vec++;
        if (wr_cnt - w0 != exp_wr) begin
            miss++; $display("FAIL write_strobes p%0d addr=%h: %0d strobes, want %0d", p, a, wr_cnt - w0, exp_wr);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk) load = 1'b0;
        vec++;
        if ({ack0_o, ack1_o, err0_o, err1_o, busy_o, mem_write_o, mem_read_o, rdata0_o, rdata1_o, mem_addr_o, mem_wdata_o} !== '0) begin
            miss++; $display("FAIL reset_outputs: ack=%b%b err=%b%b busy=%b wr=%b rd=%b rdata0=%h rdata1=%h maddr=%h, want all 0",
                ack0_o, ack1_o, err0_o, err1_o, busy_o, mem_write_o, mem_read_o, rdata0_o, rdata1_o, mem_addr_o);
        end
        rst_i = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
    endtask

    task automatic test_single_read();
        access(0, 1'b0, 32'd8, '0, 3, 32'h44332211, 1'b0, 0);
    endtask

    task automatic test_write_read();
        access(1, 1'b1, 32'd12, 32'hDEADBEEF, 3, '0, 1'b0, 1);
        access(0, 1'b0, 32'd12, '0, 3, 32'hDEADBEEF, 1'b0, 0);
        access(1, 1'b0, 32'd8, '0, 3, 32'h44332211, 1'b0, 0);
    endtask

    task automatic test_contention(input int first);
        int t [2] = '{0, 0};
        int n = 0;
        @(negedge clk);
        expect_resp(0, 1'b0, 32'h44332211, 1'b0);
        expect_resp(1, 1'b0, 32'hDEADBEEF, 1'b0);
        drive(0, 1'b0, 32'd8, '0, 1'b1);
        drive(1, 1'b0, 32'd12, '0, 1'b1);
        while ((t[0] == 0 || t[1] == 0) && n < 30) begin
            @(negedge clk);
            n++;
            if (ack0_o && t[0] == 0) begin t[0] = n; drive(0, 1'b0, 32'd8, '0, 1'b0); end
            if (ack1_o && t[1] == 0) begin t[1] = n; drive(1, 1'b0, 32'd12, '0, 1'b0); end
        end
        vec++;
        if (t[first] != 3) begin
            miss++; $display("FAIL contention_first p%0d: ack at cycle %0d, want 3", first, t[first]);
        end
        vec++;
        if (t[1-first] != 7) begin
            miss++; $display("FAIL contention_second p%0d: ack at cycle %0d, want 7", 1 - first, t[1-first]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        int w0;
        @(negedge clk);
        drive(0, 1'b1, 32'd4, 32'hFFFFFFFF, 1'b1);
        @(negedge clk);
        vec++;
        if (busy_o !== 1'b1) begin
            miss++; $display("FAIL midwrite_busy: busy=%b in first ACCESS cycle, want 1", busy_o);
        end
        w0 = wr_cnt;
        rst_i = 1'b0;
        drive(0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        vec++;
        if ({ack0_o, ack1_o, err0_o, err1_o, busy_o, mem_write_o, mem_read_o, rdata0_o, rdata1_o, mem_addr_o, mem_wdata_o} !== '0) begin
            miss++; $display("FAIL midwrite_reset_outputs: ack=%b%b busy=%b wr=%b rd=%b rdata0=%h maddr=%h mwdata=%h, want all 0",
                ack0_o, ack1_o, busy_o, mem_write_o, mem_read_o, rdata0_o, mem_addr_o, mem_wdata_o);
        end
        rst_i = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (4) @(negedge clk);
        vec++;
        if (wr_cnt != w0) begin
            miss++; $display("FAIL midwrite_strobe: %0d strobes after reset, want 0", wr_cnt - w0);
        end
        access(0, 1'b0, 32'd4, '0, 3, 32'h3CC35AA5, 1'b0, 0);
    endtask

    task automatic test_align();
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        access(0, 1'b1, 32'd2, 32'h12345678, 1, '0, 1'b1, 0);
        access(0, 1'b0, 32'd32, '0, 1, '0, 1'b1, 0);
        access(1, 1'b0, 32'd29, '0, 1, '0, 1'b1, 0);
        access(0, 1'b0, 32'd28, '0, 3, 32'h00000000, 1'b0, 0);
        access(0, 1'b0, 32'd4, '0, 3, 32'h3CC35AA5, 1'b0, 0);
`else
        access(0, 1'b1, 32'd2, 32'hCAFEF00D, 3, '0, 1'b0, 1);
        access(0, 1'b0, 32'd2, '0, 3, 32'hCAFEF00D, 1'b0, 0);
`endif
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        apply_reset();
        test_contention(0);
        access(0, 1'b0, 32'd8, '0, 3, 32'h44332211, 1'b0, 0);
        test_contention(1);
        test_reset_mid_write();
        test_align();
        repeat (2) @(negedge clk);
        vec++;
        if (q0.size() + q1.size() != 0) begin
            miss++; $display("FAIL pending_responses: %0d expected acks never seen, want 0", q0.size() + q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
